// File: rtl/vga_axil_regfile.sv
// AXI-Lite register file for the VGA block: NUM_RW control registers followed by NUM_RO status registers.
// Define VGA_AXIL_REGFILE_WSTRB_EN for byte-lane writes; otherwise only full-word strobes are accepted.
module vga_axil_regfile #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_RW = 4,
  parameter int NUM_RO = 2
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_RW*DATA_W-1:0] ctrl_o,
  input  logic [NUM_RO*DATA_W-1:0] status_i
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int IDX_W    = ADDR_W - 2;
  localparam int NUM_REGS = NUM_RW + NUM_RO;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshake semantics: a beat transfers on a posedge where valid && ready are both high;
  // every ready/valid output is a flop, so no input reaches them combinationally.
  typedef enum logic {W_ADDR_DATA, W_RESP} w_state_t;
  typedef enum logic {R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [DATA_W-1:0] ctrl_q [NUM_RW];
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              aw_hs, w_hs, w_commit, wr_ok;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_data;
  logic [STRB_W-1:0] eff_strb;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_addr_err, wr_rw_hit, rd_err;
  logic [DATA_W-1:0] rd_val;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // A channel captured on an earlier edge shows up as its ready already dropped.
  always_comb begin
    eff_addr    = aw_hs ? awaddr : aw_addr_q;
    eff_data    = w_hs ? wdata : wdata_q;
    eff_strb    = w_hs ? wstrb : wstrb_q;
    w_commit    = (w_state == W_ADDR_DATA) && (aw_hs || !awready) && (w_hs || !wready);
    wr_idx      = eff_addr[ADDR_W-1:2];
    wr_addr_err = (eff_addr[1:0] != 2'b00) || (wr_idx >= IDX_W'(NUM_REGS));
    wr_rw_hit   = !wr_addr_err && (wr_idx < IDX_W'(NUM_RW));
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
    wr_ok       = wr_rw_hit;
`else
    wr_ok       = wr_rw_hit && (eff_strb == {STRB_W{1'b1}});
`endif
    w_state_nxt = w_state;
    case (w_state)
      W_ADDR_DATA: if (w_commit) w_state_nxt = W_RESP;
      W_RESP:      if (bready)   w_state_nxt = W_ADDR_DATA;
    endcase
  end

  always_comb begin
    rd_idx = araddr[ADDR_W-1:2];
    rd_err = (araddr[1:0] != 2'b00) || (rd_idx >= IDX_W'(NUM_REGS));
    rd_val = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (rd_idx == IDX_W'(i)) rd_val = ctrl_q[i];
    for (int i = 0; i < NUM_RO; i++)
      if (rd_idx == IDX_W'(NUM_RW + i)) rd_val = status_i[i*DATA_W +: DATA_W];
    if (rd_err) rd_val = '0;
    r_state_nxt = r_state;
    case (r_state)
      R_ADDR: if (arvalid) r_state_nxt = R_DATA;
      R_DATA: if (rready)  r_state_nxt = R_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      w_state <= W_ADDR_DATA;
      r_state <= R_ADDR;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      awready   <= 1'b1;
      wready    <= 1'b1;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int i = 0; i < NUM_RW; i++) ctrl_q[i] <= '0;
    end else begin
      case (w_state)
        W_ADDR_DATA: begin
          if (w_commit) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok)
              for (int i = 0; i < NUM_RW; i++)
                if (wr_idx == IDX_W'(i))
                  for (int b = 0; b < STRB_W; b++)
                    if (eff_strb[b]) ctrl_q[i][b*8 +: 8] <= eff_data[b*8 +: 8];
          end else begin
            if (aw_hs) begin
              awready   <= 1'b0;
              aw_addr_q <= awaddr;
            end
            if (w_hs) begin
              wready  <= 1'b0;
              wdata_q <= wdata;
              wstrb_q <= wstrb;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_ADDR: begin
          if (arvalid) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_val;
            rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_o[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed bench for vga_axil_regfile: handshakes, decode errors, backpressure, strobes and reset.
module tb_vga_axil_regfile;

  logic         clk = 1'b0;
  logic         srst;
  logic [31:0]  awaddr, wdata, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] ctrl_o;
  logic [63:0]  status_i;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;

  vga_axil_regfile dut (
    .clk(clk), .srst(srst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .ctrl_o(ctrl_o), .status_i(status_i)
  );

  always #5 clk = ~clk;

  // Driver: both channels presented together, response accepted immediately.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int cnt = 0;
    logic aw_hs, w_hs;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && cnt < 20) begin
      aw_hs = awready; w_hs = wready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      cnt++;
    end
    while (!bvalid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    total_cnt++;
    if (cnt >= 20) $display("FAIL write_timeout addr=%h got no bvalid within 20 cycles", addr);
    else pass_cnt++;
    awvalid = 1'b0; wvalid = 1'b0;
    wr_resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr);
    int cnt = 0;
    logic ar_hs;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (arvalid && cnt < 20) begin
      ar_hs = arready;
      @(posedge clk); #1;
      if (ar_hs) arvalid = 1'b0;
      cnt++;
    end
    while (!rvalid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    total_cnt++;
    if (cnt >= 20) $display("FAIL read_timeout addr=%h got no rvalid within 20 cycles", addr);
    else pass_cnt++;
    arvalid = 1'b0;
    rd_data = rdata; rd_resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    status_i = {32'h0BADF00D, 32'hA5A5A5A5};
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
    total_cnt++;
    if ({awready, wready, arready} !== 3'b111) $display("FAIL reset_ready got=%b exp=111", {awready, wready, arready});
    else pass_cnt++;
    total_cnt++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0) $display("FAIL reset_valid_resp got=%b exp=000000", {bvalid, rvalid, bresp, rresp});
    else pass_cnt++;
    total_cnt++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata);
    else pass_cnt++;
    total_cnt++;
    if (ctrl_o !== 128'h0) $display("FAIL reset_ctrl got=%h exp=0", ctrl_o);
    else pass_cnt++;
  endtask

  task automatic test_write_same_cycle();
    awaddr = 32'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    total_cnt++;
    if ({bvalid, bresp, awready, wready} !== 5'b1_00_00) $display("FAIL same_cycle_bresp got=%b exp=10000", {bvalid, bresp, awready, wready});
    else pass_cnt++;
    total_cnt++;
    if (ctrl_o[63:32] !== 32'hDEADBEEF) $display("FAIL same_cycle_reg1 got=%h exp=deadbeef", ctrl_o[63:32]);
    else pass_cnt++;
    @(posedge clk); #1;
    bready = 1'b0;
    total_cnt++;
    if ({bvalid, awready, wready} !== 3'b011) $display("FAIL same_cycle_release got=%b exp=011", {bvalid, awready, wready});
    else pass_cnt++;
    axi_read(32'h4);
    total_cnt++;
    if ({rd_resp, rd_data} !== {2'b00, 32'hDEADBEEF}) $display("FAIL same_cycle_read got=%h/%b exp=deadbeef/00", rd_data, rd_resp);
    else pass_cnt++;
  endtask

  task automatic test_w_before_aw();
    awaddr = 32'h0; wdata = 32'h12345678; wstrb = 4'hF;
    wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    total_cnt++;
    if ({wready, awready, bvalid} !== 3'b010) $display("FAIL w_first_ready got=%b exp=010", {wready, awready, bvalid});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({bvalid, ctrl_o[31:0]} !== {1'b0, 32'h0}) $display("FAIL w_first_wait got=%b/%h exp=0/0", bvalid, ctrl_o[31:0]);
    else pass_cnt++;
    awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    total_cnt++;
    if ({bvalid, bresp, ctrl_o[31:0]} !== {1'b1, 2'b00, 32'h12345678}) $display("FAIL w_first_commit got=%b/%b/%h exp=1/00/12345678", bvalid, bresp, ctrl_o[31:0]);
    else pass_cnt++;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    total_cnt++;
    if ({bvalid, awready, wready} !== 3'b011) $display("FAIL w_first_release got=%b exp=011", {bvalid, awready, wready});
    else pass_cnt++;
  endtask

  task automatic test_status_ro();
    axi_read(32'h10);
    total_cnt++;
    if ({rd_resp, rd_data} !== {2'b00, 32'hA5A5A5A5}) $display("FAIL status0_read got=%h/%b exp=a5a5a5a5/00", rd_data, rd_resp);
    else pass_cnt++;
    axi_read(32'h14);
    total_cnt++;
    if ({rd_resp, rd_data} !== {2'b00, 32'h0BADF00D}) $display("FAIL status1_read got=%h/%b exp=0badf00d/00", rd_data, rd_resp);
    else pass_cnt++;
    axi_write(32'h10, 32'h0, 4'hF);
    total_cnt++;
    if (wr_resp !== 2'b10) $display("FAIL status_write_resp got=%b exp=10", wr_resp);
    else pass_cnt++;
    axi_read(32'h10);
    total_cnt++;
    if ({rd_resp, rd_data} !== {2'b00, 32'hA5A5A5A5}) $display("FAIL status_after_write got=%h/%b exp=a5a5a5a5/00", rd_data, rd_resp);
    else pass_cnt++;
    total_cnt++;
    if (ctrl_o !== {64'h0, 32'hDEADBEEF, 32'h12345678}) $display("FAIL status_ctrl_unchanged got=%h", ctrl_o);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    axi_read(32'h18);
    total_cnt++;
    if ({rd_resp, rd_data} !== {2'b10, 32'h0}) $display("FAIL oor_read got=%h/%b exp=0/10", rd_data, rd_resp);
    else pass_cnt++;
    axi_read(32'h2);
    total_cnt++;
    if ({rd_resp, rd_data} !== {2'b10, 32'h0}) $display("FAIL misaligned_read got=%h/%b exp=0/10", rd_data, rd_resp);
    else pass_cnt++;
    axi_write(32'h18, 32'hFFFFFFFF, 4'hF);
    total_cnt++;
    if (wr_resp !== 2'b10) $display("FAIL oor_write_resp got=%b exp=10", wr_resp);
    else pass_cnt++;
    axi_write(32'h6, 32'hFFFFFFFF, 4'hF);
    total_cnt++;
    if (wr_resp !== 2'b10) $display("FAIL misaligned_write_resp got=%b exp=10", wr_resp);
    else pass_cnt++;
    total_cnt++;
    if (ctrl_o !== {64'h0, 32'hDEADBEEF, 32'h12345678}) $display("FAIL error_ctrl_unchanged got=%h", ctrl_o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b00, 32'hDEADBEEF})
        $display("FAIL read_hold cycle=%0d got=%b/%b/%b/%h exp=1/0/00/deadbeef", i, rvalid, arready, rresp, rdata);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    total_cnt++;
    if ({rvalid, arready} !== 2'b01) $display("FAIL read_release got=%b exp=01", {rvalid, arready});
    else pass_cnt++;

    awaddr = 32'h8; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    total_cnt++;
    if (ctrl_o[95:64] !== 32'hCAFEF00D) $display("FAIL bp_write_reg2 got=%h exp=cafef00d", ctrl_o[95:64]);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({bvalid, bresp, awready, wready} !== 5'b1_00_00)
        $display("FAIL write_hold cycle=%0d got=%b exp=10000", i, {bvalid, bresp, awready, wready});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    total_cnt++;
    if ({bvalid, awready, wready} !== 3'b011) $display("FAIL write_release got=%b exp=011", {bvalid, awready, wready});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    awaddr = 32'h4; wdata = 32'h01020304; wstrb = 4'hF; araddr = 32'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    total_cnt++;
    if ({rvalid, rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL concurrent_old_read got=%b/%h exp=1/deadbeef", rvalid, rdata);
    else pass_cnt++;
    total_cnt++;
    if ({bvalid, ctrl_o[63:32]} !== {1'b1, 32'h01020304}) $display("FAIL concurrent_write got=%b/%h exp=1/01020304", bvalid, ctrl_o[63:32]);
    else pass_cnt++;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    total_cnt++;
    if ({bvalid, rvalid, awready, arready} !== 4'b0011) $display("FAIL concurrent_release got=%b exp=0011", {bvalid, rvalid, awready, arready});
    else pass_cnt++;
  endtask

  task automatic test_wstrb();
    axi_write(32'h4, 32'hFFFFFFFF, 4'hF);
    total_cnt++;
    if ({wr_resp, ctrl_o[63:32]} !== {2'b00, 32'hFFFFFFFF}) $display("FAIL wstrb_full got=%b/%h exp=00/ffffffff", wr_resp, ctrl_o[63:32]);
    else pass_cnt++;
    axi_write(32'h4, 32'h0, 4'h3);
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
    total_cnt++;
    if ({wr_resp, ctrl_o[63:32]} !== {2'b00, 32'hFFFF0000}) $display("FAIL wstrb_partial got=%b/%h exp=00/ffff0000", wr_resp, ctrl_o[63:32]);
    else pass_cnt++;
    axi_write(32'h4, 32'h0, 4'h0);
    total_cnt++;
    if ({wr_resp, ctrl_o[63:32]} !== {2'b00, 32'hFFFF0000}) $display("FAIL wstrb_zero got=%b/%h exp=00/ffff0000", wr_resp, ctrl_o[63:32]);
    else pass_cnt++;
`else
    total_cnt++;
    if ({wr_resp, ctrl_o[63:32]} !== {2'b10, 32'hFFFFFFFF}) $display("FAIL wstrb_partial got=%b/%h exp=10/ffffffff", wr_resp, ctrl_o[63:32]);
    else pass_cnt++;
    axi_write(32'h4, 32'h0, 4'h0);
    total_cnt++;
    if ({wr_resp, ctrl_o[63:32]} !== {2'b10, 32'hFFFFFFFF}) $display("FAIL wstrb_zero got=%b/%h exp=10/ffffffff", wr_resp, ctrl_o[63:32]);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_resp();
    awaddr = 32'hC; wdata = 32'h00000011; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    total_cnt++;
    if ({bvalid, ctrl_o[127:96]} !== {1'b1, 32'h11}) $display("FAIL pre_reset_write got=%b/%h exp=1/00000011", bvalid, ctrl_o[127:96]);
    else pass_cnt++;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    total_cnt++;
    if ({bvalid, awready, wready, arready} !== 4'b0111) $display("FAIL mid_reset_hs got=%b exp=0111", {bvalid, awready, wready, arready});
    else pass_cnt++;
    total_cnt++;
    if (ctrl_o !== 128'h0) $display("FAIL mid_reset_ctrl got=%h exp=0", ctrl_o);
    else pass_cnt++;
    axi_read(32'hC);
    total_cnt++;
    if ({rd_resp, rd_data} !== {2'b00, 32'h0}) $display("FAIL post_reset_read got=%h/%b exp=0/00", rd_data, rd_resp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_status_ro();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_wstrb();
    test_reset_mid_resp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
